// File: rtl/alarm_clock_core.sv
// alarm_clock_core: BCD 24-hour timekeeping, alarm compare and set-mode FSM.
// Optional snooze is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_clock_core #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_tick,
  input  logic       field_tick,
  input  logic       inc_tick,
  input  logic       alarm_en,
  output logic       settime,
  output logic [1:0] sel_field,
  output logic [3:0] insecMSB,
  output logic [3:0] insecLSB,
  output logic [3:0] inminMSB,
  output logic [3:0] inminLSB,
  output logic [3:0] inhourMSB,
  output logic [3:0] inhourLSB,
  output logic [3:0] alarmsecMSB,
  output logic [3:0] alarmsecLSB,
  output logic [3:0] alarmminMSB,
  output logic [3:0] alarmminLSB,
  output logic [3:0] alarmhourMSB,
  output logic [3:0] alarmhourLSB,
  output logic       alarm_ring,
  output logic       sec_tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {NORMAL, SET_TIME, SET_ALARM} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic          tick_nx;
  logic [1:0]    sel_nx;
  logic [23:0]   tim, tim_nx, alm, alm_nx;
  logic          ring_set, ring_clr, ring_nx;
  logic          mode_go, inc_go, fld_go;

  assign tim = {inhourMSB, inhourLSB, inminMSB, inminLSB, insecMSB, insecLSB};
  assign alm = {alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB};

  // Two-digit 00..59 increment; bit 8 is the carry out of 59 -> 00.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 9'h100;
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit 00..23 increment with wrap.
  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Manual increment of one field, never carrying into its neighbour.
  function automatic logic [23:0] bump(input logic [23:0] v, input logic [1:0] f);
    logic [23:0] r;
    logic [8:0]  t;
    r = v;
    case (f)
      2'd0: begin t = inc60(v[7:0]);  r[7:0]  = t[7:0]; end
      2'd1: begin t = inc60(v[15:8]); r[15:8] = t[7:0]; end
      2'd2: r[23:16] = inc24(v[23:16]);
      default: r = v;
    endcase
    return r;
  endfunction

  // Tick priority: mode beats inc beats field.
  assign mode_go = mode_tick;
  assign inc_go  = inc_tick & ~mode_tick;
  assign fld_go  = field_tick & ~inc_tick & ~mode_tick;

  // Mode FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NORMAL;
    else       state <= state_nx;
  end

  // Mode FSM next state.
  always_comb begin
    state_nx = state;
    if (mode_go) begin
      case (state)
        NORMAL:   state_nx = SET_TIME;
        SET_TIME: state_nx = SET_ALARM;
        default:  state_nx = NORMAL;
      endcase
    end
  end

  // Next-value logic for prescaler, field select, time and alarm.
  always_comb begin
    logic [8:0] s9, m9;
    s9      = 9'd0;
    m9      = 9'd0;
    sel_nx  = sel_field;
    tim_nx  = tim;
    alm_nx  = alm;
    pre_nx  = (pre == PRE_MAX) ? '0 : pre + PW'(1);
    if (state_nx == SET_TIME) pre_nx = '0;
    tick_nx = (state_nx != SET_TIME) && (pre_nx == PRE_MAX);

    if (mode_go)                       sel_nx = 2'd0;
    else if (state != NORMAL && fld_go) sel_nx = (sel_field == 2'd2) ? 2'd0 : sel_field + 2'd1;

    if (state == SET_TIME && inc_go) begin
      tim_nx = bump(tim, sel_field);
    end else if (sec_tick) begin
      s9 = inc60(tim[7:0]);
      tim_nx[7:0] = s9[7:0];
      if (s9[8]) begin
        m9 = inc60(tim[15:8]);
        tim_nx[15:8] = m9[7:0];
        if (m9[8]) tim_nx[23:16] = inc24(tim[23:16]);
      end
    end

    if (state == SET_ALARM && inc_go) alm_nx = bump(alm, sel_field);
  end

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;

  logic          snz_pend, snz_pend_nx;
  logic [SW-1:0] snz_cnt, snz_cnt_nx;

  // Ring set/clear plus snooze countdown; clear always wins over set.
  always_comb begin
    logic cancel;
    cancel      = (state == NORMAL && inc_go) || !alarm_en || mode_go;
    ring_set    = (state == NORMAL) && alarm_en && sec_tick && (tim_nx == alm);
    ring_clr    = cancel;
    snz_pend_nx = snz_pend;
    snz_cnt_nx  = snz_cnt;
    if (cancel) begin
      snz_pend_nx = 1'b0;
    end else if (state == NORMAL && fld_go && alarm_ring) begin
      snz_pend_nx = 1'b1;
      snz_cnt_nx  = SW'(SNOOZE_SEC);
      ring_clr    = 1'b1;
    end else if (snz_pend && sec_tick && state == NORMAL) begin
      snz_cnt_nx = snz_cnt - SW'(1);
      if (snz_cnt == SW'(1)) begin
        snz_pend_nx = 1'b0;
        ring_set    = 1'b1;
      end
    end
    ring_nx = ring_clr ? 1'b0 : (ring_set ? 1'b1 : alarm_ring);
  end

  // Snooze counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_pend <= 1'b0;
      snz_cnt  <= '0;
    end else begin
      snz_pend <= snz_pend_nx;
      snz_cnt  <= snz_cnt_nx;
    end
  end
`else
  // Ring set/clear; clear always wins over set.
  always_comb begin
    ring_set = (state == NORMAL) && alarm_en && sec_tick && (tim_nx == alm);
    ring_clr = (state == NORMAL && inc_go) || !alarm_en || mode_go;
    ring_nx  = ring_clr ? 1'b0 : (ring_set ? 1'b1 : alarm_ring);
  end
`endif

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      sec_tick   <= 1'b0;
      settime    <= 1'b0;
      sel_field  <= 2'd0;
      alarm_ring <= 1'b0;
      {inhourMSB, inhourLSB, inminMSB, inminLSB, insecMSB, insecLSB} <= 24'h000000;
      {alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB} <= 24'h060000;
    end else begin
      pre        <= pre_nx;
      sec_tick   <= tick_nx;
      settime    <= (state_nx != NORMAL);
      sel_field  <= sel_nx;
      alarm_ring <= ring_nx;
      {inhourMSB, inhourLSB, inminMSB, inminLSB, insecMSB, insecLSB} <= tim_nx;
      {alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB} <= alm_nx;
    end
  end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Scoreboard bench for alarm_clock_core: a seconds-of-day reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_alarm_clock_core;
  localparam int CLK_HZ = 4;
  localparam int SNZ    = 3;
  localparam int DAY    = 86400;

  logic clk = 1'b0, reset = 1'b1;
  logic mode_tick = 1'b0, field_tick = 1'b0, inc_tick = 1'b0, alarm_en = 1'b1;
  logic settime, alarm_ring, sec_tick;
  logic [1:0] sel_field;
  logic [3:0] insecMSB, insecLSB, inminMSB, inminLSB, inhourMSB, inhourLSB;
  logic [3:0] alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB, alarmhourMSB, alarmhourLSB;

  alarm_clock_core #(.CLK_HZ(CLK_HZ), .SNOOZE_SEC(SNZ)) dut (
    .clk(clk), .reset(reset), .mode_tick(mode_tick), .field_tick(field_tick),
    .inc_tick(inc_tick), .alarm_en(alarm_en), .settime(settime), .sel_field(sel_field),
    .insecMSB(insecMSB), .insecLSB(insecLSB), .inminMSB(inminMSB), .inminLSB(inminLSB),
    .inhourMSB(inhourMSB), .inhourLSB(inhourLSB),
    .alarmsecMSB(alarmsecMSB), .alarmsecLSB(alarmsecLSB), .alarmminMSB(alarmminMSB),
    .alarmminLSB(alarmminLSB), .alarmhourMSB(alarmhourMSB), .alarmhourLSB(alarmhourLSB),
    .alarm_ring(alarm_ring), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [52:0] exp_q[$];

  // Reference model: mode 0/1/2 = normal/set time/set alarm, times in seconds of day.
  int m_mode, m_sel, m_pre, m_tod, m_alm, m_snz;
  bit m_tick, m_ring, m_pend;

  function automatic logic [23:0] to_bcd(input int t);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int bump_field(input int t, input int f);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    if (f == 0) s = (s + 1) % 60;
    else if (f == 1) mi = (mi + 1) % 60;
    else h = (h + 1) % 24;
    return h * 3600 + mi * 60 + s;
  endfunction

  function automatic logic [52:0] dut_vec();
    return {settime, sel_field,
            inhourMSB, inhourLSB, inminMSB, inminLSB, insecMSB, insecLSB,
            alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB,
            alarm_ring, sec_tick};
  endfunction

  function automatic logic [52:0] model_vec();
    return {(m_mode != 0), 2'(m_sel), to_bcd(m_tod), to_bcd(m_alm), m_ring, m_tick};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_pre = 0; m_tod = 0; m_alm = 6 * 3600;
    m_tick = 0; m_ring = 0; m_pend = 0; m_snz = 0;
  endtask

  task automatic chk(input string name, input logic [52:0] act, input logic [52:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model's prediction is queued after the edge.
  task automatic step(input bit m, input bit f, input bit i);
    bit mi, ii, fi, set, clr, ntick, npend;
    int nmode, ntod, nalm, nsel, npre, nsnz;
    mode_tick = m; field_tick = f; inc_tick = i;
    mi = m; ii = i && !m; fi = f && !i && !m;
    nmode = mi ? (m_mode + 1) % 3 : m_mode;
    ntod = m_tod;
    if (m_mode == 1 && ii) ntod = bump_field(m_tod, m_sel);
    else if (m_tick) ntod = (m_tod + 1) % DAY;
    nalm = (m_mode == 2 && ii) ? bump_field(m_alm, m_sel) : m_alm;
    nsel = mi ? 0 : ((m_mode != 0 && fi) ? (m_sel + 1) % 3 : m_sel);
    npre = (nmode == 1) ? 0 : (m_pre + 1) % CLK_HZ;
    ntick = (nmode != 1) && (npre == CLK_HZ - 1);
    clr = (ii && m_mode == 0) || !alarm_en || mi;
    set = (m_mode == 0) && alarm_en && m_tick && (ntod == m_alm);
    npend = m_pend; nsnz = m_snz;
`ifdef ALARM_SNOOZE_EN
    if (clr) npend = 0;
    else if (m_mode == 0 && fi && m_ring) begin npend = 1; nsnz = SNZ; clr = 1; end
    else if (m_pend && m_tick && m_mode == 0) begin
      nsnz = m_snz - 1;
      if (nsnz == 0) begin npend = 0; set = 1; end
    end
`endif
    @(posedge clk);
    #1;
    m_ring = clr ? 0 : (set ? 1 : m_ring);
    m_mode = nmode; m_tod = ntod; m_alm = nalm; m_sel = nsel;
    m_pre = npre; m_tick = ntick; m_pend = npend; m_snz = nsnz;
    exp_q.push_back(model_vec());
    mode_tick = 0; field_tick = 0; inc_tick = 0;
  endtask

  // In a set mode, press inc until the selected field reads target.
  task automatic set_field(input int target);
    int cur, modn, n;
    cur = (m_mode == 1) ? m_tod : m_alm;
    if (m_sel == 0) begin cur = cur % 60; modn = 60; end
    else if (m_sel == 1) begin cur = (cur / 60) % 60; modn = 60; end
    else begin cur = cur / 3600; modn = 24; end
    n = (target - cur + modn) % modn;
    repeat (n) step(0, 0, 1);
  endtask

  // Enter the current set mode's fields sec, min, hour in turn.
  task automatic set_hms(input int h, input int mi, input int s);
    set_field(s); step(0, 1, 0);
    set_field(mi); step(0, 1, 0);
    set_field(h); step(0, 1, 0);
  endtask

  task automatic wait_ring(input string name);
    for (int k = 0; k < 400 && !m_ring; k++) step(0, 0, 0);
    @(negedge clk); #1;
    chk(name, {52'd0, alarm_ring}, 53'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", dut_vec(), {1'b0, 2'd0, 24'h000000, 24'h060000, 1'b0, 1'b0});
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compare each queued prediction against the DUT between edges.
  initial begin
    logic [52:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle", dut_vec(), e);
      end
    end
  end

  initial begin
    model_reset();
    #12 chk("reset_values", dut_vec(), {1'b0, 2'd0, 24'h000000, 24'h060000, 1'b0, 1'b0});
    @(posedge clk); #1 reset = 1'b0;

    // First second after reset, then a few more.
    repeat (12) step(0, 0, 0);

    // Load 23:59:58, exercise a full sec wrap, then roll over midnight.
    step(1, 0, 0);
    set_hms(23, 59, 58);
    repeat (60) step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);

    // Alarm at 00:00:05 armed, then dismiss.
    step(1, 0, 0); step(1, 0, 0);
    set_hms(0, 0, 5);
    step(1, 0, 0); step(1, 0, 0);
    set_hms(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    wait_ring("alarm_rises");
    step(0, 0, 1);
    step(0, 0, 0);
    @(negedge clk); #1 chk("dismiss", {52'd0, alarm_ring}, 53'd0);

    // Same alarm disarmed: no ring.
    alarm_en = 1'b0;
    step(1, 0, 0);
    set_hms(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    alarm_en = 1'b1;

    // mode and inc together in SET_TIME.
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    step(1, 0, 0);

    // Reset while ringing.
    step(1, 0, 0);
    set_hms(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    wait_ring("ring_before_reset");
    do_reset();

`ifdef ALARM_SNOOZE_EN
    // Snooze: alarm is back at 06:00:00 after reset.
    step(1, 0, 0);
    set_hms(5, 59, 58);
    step(1, 0, 0); step(1, 0, 0);
    wait_ring("snooze_first_ring");
    step(0, 1, 0);
    wait_ring("snooze_rering");
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    repeat (30) step(0, 0, 0);
    @(negedge clk); #1 chk("snooze_cancel", {52'd0, alarm_ring}, 53'd0);
`endif

    // Randomized ticks.
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
      step(r < 3, r >= 3 && r < 10, r >= 10 && r < 25);
    end
    repeat (4) step(0, 0, 0);
    @(negedge clk); #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
